// File: rtl/inst_fetch_resp_pkg.sv
// rtl/inst_fetch_resp_pkg.sv - shared widths, constants and fetch FSM encodings
package inst_fetch_resp_pkg;
  localparam int InstAddrBus = 32;
  localparam int InstBus     = 32;

  localparam logic [InstBus-1:0] ZeroWord = 32'h0;
  localparam logic [InstBus-1:0] NopInst  = 32'h0;

  localparam logic ChipEnable  = 1'b1;
  localparam logic ChipDisable = 1'b0;

  localparam logic [0:0] IF_IDLE   = 1'b0;
  localparam logic [0:0] IF_ACCESS = 1'b1;
endpackage

// File: rtl/inst_fetch_resp_sram_wait_timer.sv
// rtl/inst_fetch_resp_sram_wait_timer.sv - loadable SRAM wait-state counter with done flag
module sram_wait_timer #(
  parameter int WAIT_CYCLES = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic load,
  input  logic en,
  output logic done
);
  logic [3:0] count;

  // Count saturates at done; the owning FSM leaves the access on that cycle.
  always_ff @(posedge clk) begin
    if (rst || load) begin
      count <= 4'd0;
    end else if (en && !done) begin
      count <= count + 4'd1;
    end
  end

  assign done = (count == 4'(WAIT_CYCLES - 1));
endmodule

// File: rtl/inst_fetch_resp.sv
// rtl/inst_fetch_resp.sv - instruction fetch responder driving an async SRAM
// Optional one-entry reuse buffer enabled by defining INST_FETCH_REUSE_EN.
module inst_fetch_resp
  import inst_fetch_resp_pkg::*;
#(
  parameter int WAIT_CYCLES = 2,
  parameter int SRAM_AW     = 20
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   ce_i,
  input  logic [InstAddrBus-1:0] pc_i,
  input  logic                   flush_i,
  output logic [InstBus-1:0]     inst_o,
  output logic                   inst_valid_o,
  output logic                   addr_err_o,
  output logic                   stall_req_o,
  output logic [SRAM_AW-1:0]     sram_addr_o,
  output logic                   sram_ce_n_o,
  output logic                   sram_oe_n_o,
  output logic                   sram_we_n_o,
  input  logic [InstBus-1:0]     sram_data_i
);
  logic [0:0]             state;
  logic [InstAddrBus-1:0] pc_latch;
  logic                   timer_done;
  logic                   aligned;
  logic                   req;
  logic                   reuse_hit;
  logic [InstBus-1:0]     hit_inst;
  logic                   accept;
  logic                   complete;
  logic                   unused_pc_bits;

  assign aligned  = (pc_i[1:0] == 2'b00);
  assign req      = (state == IF_IDLE) && (ce_i == ChipEnable) && !flush_i;
  assign accept   = req && aligned && !reuse_hit;
  assign complete = (state == IF_ACCESS) && !flush_i && timer_done;

`ifdef INST_FETCH_REUSE_EN
  logic [InstAddrBus-1:0] last_pc;
  logic [InstBus-1:0]     last_inst;
  logic                   tag_valid;

  assign reuse_hit = req && aligned && tag_valid && (pc_i == last_pc);
  assign hit_inst  = last_inst;

  always_ff @(posedge clk) begin
    if (rst || flush_i) begin
      tag_valid <= 1'b0;
      last_pc   <= ZeroWord;
      last_inst <= ZeroWord;
    end else if (complete) begin
      tag_valid <= 1'b1;
      last_pc   <= pc_latch;
      last_inst <= sram_data_i;
    end
  end
`else
  assign reuse_hit = 1'b0;
  assign hit_inst  = ZeroWord;
`endif

  sram_wait_timer #(.WAIT_CYCLES(WAIT_CYCLES)) u_timer (
    .clk  (clk),
    .rst  (rst),
    .load (accept),
    .en   (state == IF_ACCESS),
    .done (timer_done)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state        <= IF_IDLE;
      pc_latch     <= ZeroWord;
      inst_o       <= ZeroWord;
      inst_valid_o <= 1'b0;
      addr_err_o   <= 1'b0;
    end else begin
      inst_valid_o <= 1'b0;
      addr_err_o   <= 1'b0;
      case (state)
        IF_IDLE: begin
          if (req && !aligned) begin
            inst_o       <= NopInst;
            inst_valid_o <= 1'b1;
            addr_err_o   <= 1'b1;
          end else if (reuse_hit) begin
            inst_o       <= hit_inst;
            inst_valid_o <= 1'b1;
          end else if (accept) begin
            pc_latch <= pc_i;
            state    <= IF_ACCESS;
          end
        end
        IF_ACCESS: begin
          // Flush wins over a same-cycle completion: the word is dropped.
          if (flush_i) begin
            state <= IF_IDLE;
          end else if (complete) begin
            inst_o       <= sram_data_i;
            inst_valid_o <= 1'b1;
            state        <= IF_IDLE;
          end
        end
        default: state <= IF_IDLE;
      endcase
    end
  end

  assign stall_req_o = (state == IF_ACCESS) || accept;
  assign sram_ce_n_o = ~((state == IF_ACCESS) ? ChipEnable : ChipDisable);
  assign sram_oe_n_o = sram_ce_n_o;
  assign sram_we_n_o = 1'b1;
  assign sram_addr_o = pc_latch[SRAM_AW+1:2];

  assign unused_pc_bits = ^{pc_latch[InstAddrBus-1:SRAM_AW+2], pc_latch[1:0]};
endmodule

// File: tb/tb_inst_fetch_resp.sv
// tb/tb_inst_fetch_resp.sv - directed self-checking bench for inst_fetch_resp
module tb_inst_fetch_resp;
  logic        clk = 1'b0;
  logic        rst;
  logic        ce;
  logic [31:0] pc;
  logic        flush;
  logic [31:0] inst;
  logic        inst_valid;
  logic        addr_err;
  logic        stall;
  logic [19:0] sram_addr;
  logic        sram_ce_n;
  logic        sram_oe_n;
  logic        sram_we_n;
  logic [31:0] sram_data;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  // SRAM model: word n holds 0x2401_0001 + n; garbage when deselected.
  assign sram_data = (sram_ce_n || sram_oe_n) ? 32'hDEAD_BEEF
                                              : 32'h2401_0001 + {12'h0, sram_addr};

  inst_fetch_resp #(.WAIT_CYCLES(2), .SRAM_AW(20)) dut (
    .clk          (clk),
    .rst          (rst),
    .ce_i         (ce),
    .pc_i         (pc),
    .flush_i      (flush),
    .inst_o       (inst),
    .inst_valid_o (inst_valid),
    .addr_err_o   (addr_err),
    .stall_req_o  (stall),
    .sram_addr_o  (sram_addr),
    .sram_ce_n_o  (sram_ce_n),
    .sram_oe_n_o  (sram_oe_n),
    .sram_we_n_o  (sram_we_n),
    .sram_data_i  (sram_data)
  );

  function automatic logic [31:0] word_at(input logic [31:0] byte_addr);
    return 32'h2401_0001 + (byte_addr >> 2);
  endfunction

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Issue one fetch, count edges to the valid strobe, stall cycles and SRAM cycles.
  task automatic do_fetch(input string tag, input logic [31:0] a, input int exp_lat,
                          input int exp_stall, input int exp_sram,
                          input logic [31:0] exp_inst, input logic exp_err);
    int n = 0;
    int s = 0;
    int c = 0;
    ce = 1'b1;
    pc = a;
    #1;
    while (n < 20) begin
      if (stall) s++;
      if (!sram_ce_n && !sram_oe_n) begin
        c++;
        if (c == 1) check({tag, "_addr"}, 32'(sram_addr), a >> 2);
      end
      step();
      n++;
      if (inst_valid) break;
    end
    check({tag, "_lat"}, 32'(n), 32'(exp_lat));
    check({tag, "_stall"}, 32'(s), 32'(exp_stall));
    check({tag, "_sram"}, 32'(c), 32'(exp_sram));
    check({tag, "_inst"}, inst, exp_inst);
    check({tag, "_err"}, 32'(addr_err), 32'(exp_err));
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1);
  end

  initial begin
    int seen;
    rst = 1'b1; ce = 1'b0; pc = 32'h0; flush = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check("rst_inst", inst, 32'h0);
    check("rst_valid", 32'(inst_valid), 32'h0);
    check("rst_err", 32'(addr_err), 32'h0);
    check("rst_ce_n", 32'(sram_ce_n), 32'h1);
    check("rst_oe_n", 32'(sram_oe_n), 32'h1);
    check("rst_we_n", 32'(sram_we_n), 32'h1);
    check("rst_addr", 32'(sram_addr), 32'h0);
    check("rst_stall", 32'(stall), 32'h0);
    rst = 1'b0;
    step();

    do_fetch("t1", 32'h10, 3, 3, 2, 32'h2401_0005, 1'b0);
    ce = 1'b0;
    #1;
    check("t1_idle_stall", 32'(stall), 32'h0);
    step();
    check("t1_valid_drop", 32'(inst_valid), 32'h0);
    check("t1_hold", inst, 32'h2401_0005);

    do_fetch("t2a", 32'h0, 3, 3, 2, word_at(32'h0), 1'b0);
    do_fetch("t2b", 32'h4, 3, 3, 2, word_at(32'h4), 1'b0);
    do_fetch("t2c", 32'h8, 3, 3, 2, word_at(32'h8), 1'b0);
    ce = 1'b0;
    step();

    ce = 1'b1; pc = 32'h20;
    step();
    ce = 1'b0;
    step();
    flush = 1'b1;
    #1;
    check("t3_stall_acc", 32'(stall), 32'h1);
    step();
    flush = 1'b0;
    #1;
    check("t3_valid", 32'(inst_valid), 32'h0);
    check("t3_ce_n", 32'(sram_ce_n), 32'h1);
    check("t3_stall", 32'(stall), 32'h0);
    seen = 0;
    for (int i = 0; i < 4; i++) begin
      step();
      if (inst_valid) seen++;
    end
    check("t3_no_strobe", 32'(seen), 32'h0);
    check("t3_inst_kept", inst, word_at(32'h8));
    do_fetch("t3_next", 32'h40, 3, 3, 2, word_at(32'h40), 1'b0);
    ce = 1'b0;
    step();

    ce = 1'b1; pc = 32'h30; flush = 1'b1;
    #1;
    check("fi_stall", 32'(stall), 32'h0);
    step();
    check("fi_valid", 32'(inst_valid), 32'h0);
    check("fi_ce_n", 32'(sram_ce_n), 32'h1);
    ce = 1'b0; flush = 1'b0;
    step();

    do_fetch("t4", 32'h6, 1, 0, 0, 32'h0, 1'b1);
    ce = 1'b0;
    step();
    check("t4_valid_drop", 32'(inst_valid), 32'h0);
    check("t4_err_drop", 32'(addr_err), 32'h0);

    ce = 1'b1; pc = 32'h60;
    step();
    pc = 32'h74; ce = 1'b0;
    #1;
    check("pc_hold_addr", 32'(sram_addr), 32'h18);
    step();
    step();
    check("pc_hold_valid", 32'(inst_valid), 32'h1);
    check("pc_hold_inst", inst, word_at(32'h60));
    step();

    ce = 1'b1; pc = 32'h50;
    step();
    ce = 1'b0; rst = 1'b1;
    step();
    check("t5_inst", inst, 32'h0);
    check("t5_valid", 32'(inst_valid), 32'h0);
    check("t5_ce_n", 32'(sram_ce_n), 32'h1);
    check("t5_oe_n", 32'(sram_oe_n), 32'h1);
    check("t5_addr", 32'(sram_addr), 32'h0);
    check("t5_stall", 32'(stall), 32'h0);
    rst = 1'b0;
    step();
    check("t5_after", 32'(inst_valid), 32'h0);

    do_fetch("t6_fill", 32'h100, 3, 3, 2, word_at(32'h100), 1'b0);
    ce = 1'b0;
    step();
`ifdef INST_FETCH_REUSE_EN
    do_fetch("t6_hit", 32'h100, 1, 0, 0, word_at(32'h100), 1'b0);
`else
    do_fetch("t6_again", 32'h100, 3, 3, 2, word_at(32'h100), 1'b0);
`endif
    ce = 1'b0; flush = 1'b1;
    step();
    flush = 1'b0;
    do_fetch("t6_flushed", 32'h100, 3, 3, 2, word_at(32'h100), 1'b0);
    ce = 1'b0;
    step();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
